// File: rtl/move_input_ctrl.sv
// Column-select front end for one player: synchronizes and debounces the three
// raw buttons, then walks a cursor over the 7 columns and issues one move per turn.
module move_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_confirm,
  input  logic       enable,
  input  logic [6:0] col_full,
  output logic [2:0] move_col,
  output logic       move_valid,
  output logic [2:0] cursor_col,
  output logic       reject,
  output logic       sel_active
);

  localparam int              CW       = 16;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      COL_HOME = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT_RELEASE
  } state_t;

  function automatic logic [2:0] f_cursor_inc(input logic [2:0] c);
    return (c == 3'd6) ? 3'd0 : c + 3'd1;
  endfunction

  function automatic logic [2:0] f_cursor_dec(input logic [2:0] c);
    return (c == 3'd0) ? 3'd6 : c - 3'd1;
  endfunction

  // Bit order in all per-button vectors: {confirm, right, left}
  logic [2:0]    w_btn_raw;
  logic [2:0]    r_btn_p0;
  logic [2:0]    r_btn_p1;
  logic [2:0]    r_db;
  logic [2:0]    r_db_d;
  logic [2:0]    r_evt;
  logic [CW-1:0] r_cnt [3];

  assign w_btn_raw = {btn_confirm, btn_right, btn_left};

  // Stage p0/p1: two-flop synchronizer, then debounce counter and rising-edge event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_p0 <= '0;
      r_btn_p1 <= '0;
      r_db     <= '0;
      r_db_d   <= '0;
      r_evt    <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_btn_p0 <= w_btn_raw;
      r_btn_p1 <= r_btn_p0;
      r_db_d   <= r_db;
      r_evt    <= r_db & ~r_db_d;
      for (int i = 0; i < 3; i++) begin
        if (r_btn_p1[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_db[i]  <= ~r_db[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic       w_evt_left;
  logic       w_evt_right;
  logic       w_evt_confirm;
  logic [7:0] w_full;

  assign w_evt_left    = r_evt[0];
  assign w_evt_right   = r_evt[1];
  assign w_evt_confirm = r_evt[2];
  assign w_full        = {1'b0, col_full};

  state_t     r_state;
  logic [2:0] r_cursor;
  logic [2:0] r_move_col;
  logic       r_move_valid;
  logic       r_reject;

  // Turn FSM: move_valid is registered on entry to ISSUE so it spans exactly that state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cursor     <= COL_HOME;
      r_move_col   <= '0;
      r_move_valid <= 1'b0;
      r_reject     <= 1'b0;
    end else begin
      r_move_valid <= 1'b0;
      r_reject     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state  <= ST_SELECT;
            r_cursor <= COL_HOME;
          end
        end
        ST_SELECT: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else begin
            if (w_evt_left && !w_evt_right) begin
              r_cursor <= f_cursor_dec(r_cursor);
            end else if (w_evt_right && !w_evt_left) begin
              r_cursor <= f_cursor_inc(r_cursor);
            end
            // Column chosen is the cursor before any same-cycle left/right move
            if (w_evt_confirm) begin
              if (w_full[r_cursor]) begin
                r_reject <= 1'b1;
              end else begin
                r_state      <= ST_ISSUE;
                r_move_col   <= r_cursor;
                r_move_valid <= 1'b1;
              end
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT_RELEASE;
        end
        ST_WAIT_RELEASE: begin
          if (!enable) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign move_col   = r_move_col;
  assign move_valid = r_move_valid;
  assign cursor_col = r_cursor;
  assign reject     = r_reject;
  assign sel_active = (r_state == ST_SELECT);

endmodule
